// File: rtl/snn_frame_loader_pkg.sv
// Shared types and helpers for the SNN image loader slice.
package snn_pkg;

    localparam int NUM_PIXELS_DEF = 784;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FULL = 2'd2
    } fill_state_t;

    function automatic int bytes_per_img(input int num_pixels);
        return (num_pixels + 7) / 8;
    endfunction

endpackage

// File: rtl/snn_frame_loader_if.sv
// UART-byte / core-read bundle between the frame loader and its neighbours.
interface snn_frame_loader_if #(
    parameter int ADDR_W = $clog2(snn_pkg::NUM_PIXELS_DEF)
);
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic [ADDR_W-1:0] core_addr;
    logic              core_done;
    logic              q;
    logic              start;
    logic              frame_err;
    logic              overrun;
    logic              img_pending;
    logic              active_bank;

    modport master (
        output rx_rdy, rx_data, core_addr, core_done,
        input  q, start, frame_err, overrun, img_pending, active_bank
    );

    modport slave (
        input  rx_rdy, rx_data, core_addr, core_done,
        output q, start, frame_err, overrun, img_pending, active_bank
    );
endinterface

// File: rtl/snn_frame_loader_bit_bank.sv
// One image bank: bit-addressed storage, byte-wide masked write, registered 1-bit read.
module snn_bit_bank
    import snn_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int ADDR_W     = $clog2(NUM_PIXELS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-4:0] byte_idx,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rdata
);
    localparam logic [ADDR_W:0] PIX_LIMIT = (ADDR_W + 1)'(NUM_PIXELS);

    logic mem [NUM_PIXELS];
    logic rd_r;

    // byte write; pixels past the end of the image are dropped
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if ({1'b0, byte_idx, i[2:0]} < PIX_LIMIT) begin
                    mem[{byte_idx, i[2:0]}] <= wdata[i];
                end
            end
        end
    end

    // registered read, out-of-range addresses read as 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_r <= 1'b0;
        end else if ({1'b0, raddr} < PIX_LIMIT) begin
            rd_r <= mem[raddr];
        end else begin
            rd_r <= 1'b0;
        end
    end

    assign rdata = rd_r;
endmodule

// File: rtl/snn_frame_loader.sv
// Double-buffered UART-to-core image loader: fills one bank while the core reads the other,
// with inter-byte timeout resync and overrun reporting.
module snn_frame_loader
    import snn_pkg::*;
#(
    parameter int NUM_PIXELS  = NUM_PIXELS_DEF,
    parameter int ADDR_W      = $clog2(NUM_PIXELS),
    parameter int TIMEOUT_CYC = 500_000,
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    snn_frame_loader_if.slave bus
);
    localparam int BYTES = bytes_per_img(NUM_PIXELS);
    localparam int PTR_W = ADDR_W - 3;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);

    fill_state_t      state_r, state_s;
    logic [PTR_W-1:0] byte_ptr_r;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             core_busy_r, active_bank_r, rd_sel_r;
    logic             start_r, frame_err_r, overrun_r, img_pending_r;
    logic             wr_s, last_s, tmo_s, swap_s, overrun_s;
    logic [7:0]       wdata_s;
    logic [1:0]       rd_s;

    // fill FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // fill FSM next state; a last byte that can swap at once skips FULL entirely
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, RECV: begin
                if (wr_s) begin
                    if (last_s) begin
                        state_s = swap_s ? IDLE : FULL;
                    end else begin
                        state_s = RECV;
                    end
                end else if (tmo_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            FULL: begin
                if (swap_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = FULL;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM decode: byte accept, timeout expiry (a byte beats it), swap and overrun
    always_comb begin
        wr_s      = bus.rx_rdy && (state_r != FULL);
        last_s    = wr_s && (byte_ptr_r == LAST_PTR);
        tmo_s     = (state_r == RECV) && !bus.rx_rdy && (tmo_cnt_r == CNT_MAX);
        swap_s    = (last_s || (state_r == FULL)) && (!core_busy_r || bus.core_done);
        overrun_s = bus.rx_rdy && (state_r == FULL);
        wdata_s   = LSB_FIRST ? bus.rx_data : {<<{bus.rx_data}};
    end

    // byte pointer, inter-byte timer, core ownership and bank select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_ptr_r    <= '0;
            tmo_cnt_r     <= '0;
            core_busy_r   <= 1'b0;
            active_bank_r <= 1'b0;
            rd_sel_r      <= 1'b0;
        end else begin
            if (wr_s) begin
                byte_ptr_r <= last_s ? '0 : byte_ptr_r + 1'b1;
            end else if (tmo_s) begin
                byte_ptr_r <= '0;
            end
            if ((state_r != RECV) || bus.rx_rdy || tmo_s) begin
                tmo_cnt_r <= '0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + 1'b1;
            end
            if (swap_s) begin
                core_busy_r <= 1'b1;
            end else if (bus.core_done) begin
                core_busy_r <= 1'b0;
            end
            if (swap_s) begin
                active_bank_r <= ~active_bank_r;
            end
            rd_sel_r <= active_bank_r;
        end
    end

    // registered strobes and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_r       <= 1'b0;
            frame_err_r   <= 1'b0;
            overrun_r     <= 1'b0;
            img_pending_r <= 1'b0;
        end else begin
            start_r       <= swap_s;
            frame_err_r   <= tmo_s;
            overrun_r     <= overrun_s;
            img_pending_r <= (state_s == FULL);
        end
    end

    // the fill bank is always the one the core is not reading
    snn_bit_bank #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W)) u_bank0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wr_s && active_bank_r),
        .byte_idx (byte_ptr_r),
        .wdata    (wdata_s),
        .raddr    (bus.core_addr),
        .rdata    (rd_s[0])
    );

    snn_bit_bank #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W)) u_bank1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wr_s && !active_bank_r),
        .byte_idx (byte_ptr_r),
        .wdata    (wdata_s),
        .raddr    (bus.core_addr),
        .rdata    (rd_s[1])
    );

    assign bus.q           = rd_sel_r ? rd_s[1] : rd_s[0];
    assign bus.start       = start_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.overrun     = overrun_r;
    assign bus.img_pending = img_pending_r;
    assign bus.active_bank = active_bank_r;
endmodule

// File: tb/tb_snn_frame_loader.sv
// Bench for snn_frame_loader: frame-level reference model checked every cycle plus literal spot checks.
module tb_snn_frame_loader;
    localparam int NP   = 784;
    localparam int AW   = 10;
    localparam int NB   = 98;
    localparam int TMO  = 100;
    localparam int AW_B = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    snn_frame_loader_if #(.ADDR_W(AW))   bus_a ();
    snn_frame_loader_if #(.ADDR_W(AW_B)) bus_b ();

    snn_frame_loader #(.NUM_PIXELS(NP), .ADDR_W(AW), .TIMEOUT_CYC(TMO), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

    snn_frame_loader #(.NUM_PIXELS(20), .ADDR_W(AW_B), .TIMEOUT_CYC(TMO), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    int n_checks = 0;
    int n_fail   = 0;
    int n_start = 0, n_ferr = 0, n_pend = 0;

    // reference model: which image sits where, and what each output must be next cycle
    bit img   [2][NP];
    bit known [2][NP];
    int m_bytes, m_idle;
    bit m_full, m_busy, m_active;
    logic e_q, e_start, e_ferr, e_ovr, e_pend, e_act;
    bit e_q_known;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int idx;
        e_q_known = (bus_a.core_addr < NP) ? known[m_active][bus_a.core_addr] : 1'b1;
        e_q   = (bus_a.core_addr < NP) ? img[m_active][bus_a.core_addr] : 1'b0;
        e_ovr = bus_a.rx_rdy && m_full;
        e_ferr = 1'b0;
        if (bus_a.rx_rdy && !m_full) begin
            for (int i = 0; i < 8; i++) begin
                idx = m_bytes * 8 + i;
                if (idx < NP) begin
                    img[!m_active][idx]   = bus_a.rx_data[i];
                    known[!m_active][idx] = 1'b1;
                end
            end
            m_bytes++;
            m_idle = 0;
            if (m_bytes == NB) begin
                m_full  = 1'b1;
                m_bytes = 0;
            end
        end else if (m_bytes > 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                e_ferr  = 1'b1;
                m_bytes = 0;
                m_idle  = 0;
            end
        end
        e_start = m_full && (!m_busy || bus_a.core_done);
        if (e_start) begin
            m_active = !m_active;
            m_full   = 1'b0;
            m_busy   = 1'b1;
        end else if (bus_a.core_done) begin
            m_busy = 1'b0;
        end
        e_pend = m_full;
        e_act  = m_active;
    endtask

    // the one compare process: every falling edge, outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_q", bus_a.q, 0);
                check("rst_start", bus_a.start, 0);
                check("rst_frame_err", bus_a.frame_err, 0);
                check("rst_overrun", bus_a.overrun, 0);
                check("rst_img_pending", bus_a.img_pending, 0);
                check("rst_active_bank", bus_a.active_bank, 0);
                m_bytes = 0; m_idle = 0; m_full = 0; m_busy = 0; m_active = 0;
                e_q = 0; e_start = 0; e_ferr = 0; e_ovr = 0; e_pend = 0; e_act = 0;
                e_q_known = 1'b1;
            end else begin
                if (e_q_known) check("q", bus_a.q, e_q);
                check("start", bus_a.start, e_start);
                check("frame_err", bus_a.frame_err, e_ferr);
                check("overrun", bus_a.overrun, e_ovr);
                check("img_pending", bus_a.img_pending, e_pend);
                check("active_bank", bus_a.active_bank, e_act);
                n_start += int'(bus_a.start);
                n_ferr  += int'(bus_a.frame_err);
                n_pend  += int'(bus_a.img_pending);
                model_step();
            end
        end
    end

    task automatic cyc(input logic r, input logic [7:0] d, input logic done, input logic [AW-1:0] a);
        bus_a.rx_rdy = r; bus_a.rx_data = d; bus_a.core_done = done; bus_a.core_addr = a;
        @(posedge clk); #2;
        bus_a.rx_rdy = 1'b0; bus_a.core_done = 1'b0;
    endtask

    task automatic cyc_b(input logic r, input logic [7:0] d, input logic [AW_B-1:0] a);
        bus_b.rx_rdy = r; bus_b.rx_data = d; bus_b.core_done = 1'b0; bus_b.core_addr = a;
        @(posedge clk); #2;
        bus_b.rx_rdy = 1'b0;
    endtask

    initial begin
        int s0, p0, f0, waited;
        bit got;
        bus_a.rx_rdy = 1'b0; bus_a.rx_data = 8'h00; bus_a.core_done = 1'b0; bus_a.core_addr = '0;
        bus_b.rx_rdy = 1'b0; bus_b.rx_data = 8'h00; bus_b.core_done = 1'b0; bus_b.core_addr = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(0, 8'h00, 0, 0);

        // narrow, MSB-first instance: 0x80,0x00,0xF0 -> pixels 0,16..19
        cyc_b(1, 8'h80, 0);
        cyc_b(1, 8'h00, 0);
        cyc_b(1, 8'hF0, 0);
        check("b_start", bus_b.start, 1);
        check("b_active_bank", bus_b.active_bank, 1);
        for (int a = 0; a < 24; a++) begin
            cyc_b(0, 8'h00, AW_B'(a));
            check($sformatf("b_q_addr%0d", a), bus_b.q, ((a == 0) || (a >= 16 && a <= 19)) ? 1 : 0);
        end

        // single image, byte k = k, core idle
        s0 = n_start;
        for (int k = 0; k < NB; k++) cyc(1, 8'(k), 0, 0);
        check("img1_start_t1", bus_a.start, 1);
        check("img1_active_bank", bus_a.active_bank, 1);
        cyc(0, 8'h00, 0, 8);
        check("img1_q_addr8", bus_a.q, 1);
        cyc(0, 8'h00, 0, 783);
        check("img1_q_addr783", bus_a.q, 0);
        cyc(0, 8'h00, 0, 17);
        check("img1_q_addr17", bus_a.q, 1);
        check("img1_start_count", n_start - s0, 1);

        // second image while the core is busy, then an overrun byte
        s0 = n_start;
        for (int k = 0; k < NB; k++) cyc(1, ~8'(k), 0, 0);
        check("img2_pending", bus_a.img_pending, 1);
        check("img2_no_start", bus_a.start, 0);
        cyc(1, 8'h00, 0, 0);
        check("img2_overrun", bus_a.overrun, 1);
        check("img2_still_pending", bus_a.img_pending, 1);
        repeat (3) cyc(0, 8'h00, 0, 8);
        cyc(0, 8'h00, 1, 0);
        check("img2_start_after_done", bus_a.start, 1);
        check("img2_active_bank", bus_a.active_bank, 0);
        cyc(0, 8'h00, 0, 0);
        check("img2_q_addr0", bus_a.q, 1);
        cyc(0, 8'h00, 0, 8);
        check("img2_q_addr8", bus_a.q, 0);
        check("img2_start_count", n_start - s0, 1);

        // last byte together with core_done
        s0 = n_start; p0 = n_pend;
        for (int k = 0; k < NB - 1; k++) cyc(1, 8'(k + 5), 0, 0);
        cyc(1, 8'd102, 1, 0);
        check("sim_start", bus_a.start, 1);
        check("sim_active_bank", bus_a.active_bank, 1);
        cyc(0, 8'h00, 0, 0);
        check("sim_no_pending", n_pend - p0, 0);
        check("sim_start_count", n_start - s0, 1);

        // timeout after 40 bytes
        f0 = n_ferr;
        for (int k = 0; k < 40; k++) cyc(1, 8'(k), 0, 0);
        waited = 0; got = 1'b0;
        while (!got && waited < 3 * TMO) begin
            cyc(0, 8'h00, 0, 0);
            waited++;
            if (bus_a.frame_err) got = 1'b1;
        end
        check("tmo_seen", got, 1);
        check("tmo_latency", waited, TMO);
        check("tmo_byte_ptr", dut.byte_ptr_r, 0);
        cyc(0, 8'h00, 0, 0);
        check("tmo_err_count", n_ferr - f0, 1);
        cyc(0, 8'h00, 1, 0);
        s0 = n_start;
        for (int k = 0; k < NB; k++) cyc(1, 8'(k) ^ 8'h5A, 0, 0);
        repeat (2) cyc(0, 8'h00, 0, 0);
        check("tmo_next_start_count", n_start - s0, 1);
        check("tmo_next_active_bank", bus_a.active_bank, 0);

        // reset in the middle of a frame
        for (int k = 0; k < 50; k++) cyc(1, 8'hC3, 0, 0);
        rst_n = 1'b0;
        cyc(0, 8'h00, 0, 0);
        check("rst_mid_active_bank", bus_a.active_bank, 0);
        check("rst_mid_img_pending", bus_a.img_pending, 0);
        check("rst_mid_byte_ptr", dut.byte_ptr_r, 0);
        rst_n = 1'b1;
        cyc(0, 8'h00, 0, 0);
        s0 = n_start;
        for (int k = 0; k < NB; k++) cyc(1, 8'(k), 0, 0);
        cyc(0, 8'h00, 0, 8);
        check("rst_new_q_addr8", bus_a.q, 1);
        cyc(0, 8'h00, 0, 0);
        check("rst_new_start_count", n_start - s0, 1);
        check("rst_new_active_bank", bus_a.active_bank, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
